// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the serial adder
package serial_adder_pkg;

  // Controller states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIGIT = 1;

  // Digit counter width: clog2(N), never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH / DEFAULT_DIGIT);

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - DIGIT-bit ripple adder built from half-adder pairs
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] carry;

  assign carry[0] = ci;

  // Each full adder: first half adder on x/y, second on the partial sum and carry-in
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    logic p, g1, g2;
    assign p          = x[i] ^ y[i];
    assign g1         = x[i] & y[i];
    assign sum[i]     = p ^ carry[i];
    assign g2         = p & carry[i];
    assign carry[i+1] = g1 | g2;
  end

  assign co   = carry[DIGIT];
  // Carry into the top bit of the digit; only meaningful for the last digit
  assign cmsb = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle digit-serial adder/subtractor
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx;
  logic            cy;
  logic            load, step, last;
  logic [DIGIT-1:0] dsum;
  logic            dco, dcmsb;

  assign last = (cnt == CW'(N - 1));

  // Single shared digit adder works on the low digit of the operand shifters
  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .ci   (cy),
    .sum  (dsum),
    .co   (dco),
    .cmsb (dcmsb)
  );

  // Result shifter: new sum digit enters at the top, LSB digit ends up at bit 0
  always_comb begin
    r_nx = r_sh >> DIGIT;
    r_nx[WIDTH-1 -: DIGIT] = dsum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and control decode
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand/carry/result shifters and digit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= sub ? ~b : b;
      cy   <= sub ? 1'b1 : cin;
      r_sh <= '0;
      cnt  <= '0;
    end else if (step) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      r_sh <= r_nx;
      cy   <= dco;
      cnt  <= cnt + CW'(1);
    end
  end

  // Output registers, updated only on the final digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      c    <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= step & last;
      if (step && last) begin
        s   <= r_nx;
        c   <= dco;
        ovf <= dcmsb ^ dco;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

  typedef struct {
    int         inst;
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go;
  logic       sub_i, cin_i;
  logic [7:0] a_i, b_i;
  int         sel;

  logic       rdy_d  [3];
  logic       done_d [3];
  logic [7:0] s_d    [3];
  logic       c_d    [3];
  logic       ovf_d  [3];
  logic       start_d[3];

  int checks = 0;
  int errors = 0;
  int n_of[3] = '{8, 2, 1};

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 3; k++) start_d[k] = go && (sel == k);
  end

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_d[0]), .sub(sub_i), .cin(cin_i),
    .a(a_i), .b(b_i), .ready(rdy_d[0]), .done(done_d[0]), .s(s_d[0]),
    .c(c_d[0]), .ovf(ovf_d[0]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_d[1]), .sub(sub_i), .cin(cin_i),
    .a(a_i), .b(b_i), .ready(rdy_d[1]), .done(done_d[1]), .s(s_d[1]),
    .c(c_d[1]), .ovf(ovf_d[1]));

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start_d[2]), .sub(sub_i), .cin(cin_i),
    .a(a_i), .b(b_i), .ready(rdy_d[2]), .done(done_d[2]), .s(s_d[2]),
    .c(c_d[2]), .ovf(ovf_d[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  function automatic vec_t model(input int inst, input logic sub, input logic cin,
                                 input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    int ua, ub, sa, sb, ures, sres;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      ures = ua + ub + int'(cin);
      sres = sa + sb + int'(cin);
      v.c  = (ures > 255);
    end else begin
      ures = ua - ub;
      sres = sa - sb;
      v.c  = (ua >= ub);
    end
    v.inst = inst;
    v.sub  = sub;
    v.cin  = cin;
    v.a    = a;
    v.b    = b;
    v.s    = ures[7:0];
    v.ovf  = (sres > 127) || (sres < -128);
    return v;
  endfunction

  // Drive a request now; it is sampled at the next rising edge
  task automatic launch(input vec_t v);
    sel   = v.inst;
    sub_i = v.sub;
    cin_i = v.cin;
    a_i   = v.a;
    b_i   = v.b;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    chk("busy_after_start", rdy_d[sel], 1'b0);
  endtask

  // Wait for done, returning #1 after the edge that raised it
  task automatic wait_done(input vec_t v, input bit noisy);
    int cyc  = 0;
    int busy = 1;
    bit seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (noisy) begin
        go    = 1'($urandom_range(0, 1));
        a_i   = 8'($urandom);
        b_i   = 8'($urandom);
        sub_i = 1'($urandom);
        cin_i = 1'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done_d[sel]) seen = 1'b1;
      else if (!rdy_d[sel]) busy++;
    end
    go = 1'b0;
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", cyc, n_of[sel]);
      chk("busy_cycles", busy, n_of[sel]);
      chk("ready_in_done", rdy_d[sel], 1'b1);
      chk("s", s_d[sel], v.s);
      chk("c", c_d[sel], v.c);
      chk("ovf", ovf_d[sel], v.ovf);
    end
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   pulses;

    tbl[0] = '{0, 1'b0, 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{0, 1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    tbl[2] = '{0, 1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    tbl[3] = '{0, 1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{1, 1'b0, 1'b0, 8'hA7, 8'h59, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{2, 1'b0, 1'b0, 8'hA7, 8'h59, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0;
    go    = 1'b0;
    sel   = 0;
    sub_i = 1'b0;
    cin_i = 1'b0;
    a_i   = 8'h00;
    b_i   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", rdy_d[k], 1'b1);
      chk("rst_done", done_d[k], 1'b0);
      chk("rst_s", s_d[k], 8'h00);
      chk("rst_c", c_d[k], 1'b0);
      chk("rst_ovf", ovf_d[k], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      launch(tbl[i]);
      wait_done(tbl[i], 1'b0);
    end

    // Start asserted in the done cycle is accepted immediately
    @(negedge clk);
    launch(tbl[3]);
    wait_done(tbl[3], 1'b0);
    v = '{0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0};
    launch(v);
    wait_done(v, 1'b0);
    @(posedge clk);
    #1;
    chk("done_single_cycle", done_d[0], 1'b0);

    // Start pulses and operand changes during RUN are ignored
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      v = model(k, 1'b0, 1'b1, 8'h3A, 8'hC5);
      launch(v);
      wait_done(v, 1'b1);
      pulses = 0;
      repeat (n_of[k] + 3) begin
        @(posedge clk);
        #1;
        if (done_d[k]) pulses++;
      end
      chk("extra_done", pulses, 0);
      chk("s_held", s_d[k], v.s);
    end

    // Random operations against the arithmetic model, some back-to-back
    for (int i = 0; i < 40; i++) begin
      v = model(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 0 || v.inst != sel) @(negedge clk);
      launch(v);
      wait_done(v, 1'b0);
    end

    // Reset in the 4th RUN cycle discards the operation
    @(negedge clk);
    v = tbl[0];
    launch(v);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", rdy_d[0], 1'b1);
    chk("mid_rst_done", done_d[0], 1'b0);
    chk("mid_rst_s", s_d[0], 8'h00);
    chk("mid_rst_c", c_d[0], 1'b0);
    chk("mid_rst_ovf", ovf_d[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) if (done_d[k]) pulses++;
    end
    chk("done_after_rst", pulses, 0);
    chk("ready_after_rst", rdy_d[0], 1'b1);
    chk("s_after_rst", s_d[0], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
